// File: rtl/icache_pkg.sv
// icache_pkg: FSM state type and geometry helpers shared by the icache_nway slice.
package icache_pkg;

   typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

   function automatic int calc_sets(input int cap, input int ws, input int bw, input int ways);
      return cap / (ws * bw * ways);
   endfunction

   // Field width in the address (0 when the field vanishes).
   function automatic int lg(input int n);
      return $clog2(n);
   endfunction

   // Vector width needed to hold an index 0..n-1 (never 0).
   function automatic int wd(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// icache_victim_sel: per-set refill way choice; lowest invalid way, else FIFO pointer.
// Ports: clk/rst (sync, active-low), set_valid (valid bits of the addressed set),
//        idx (set index), commit (line being written this edge), clear (flush),
//        victim (way to fill).
module icache_victim_sel
   import icache_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 32,
   parameter int WW   = wd(WAYS),
   parameter int IW   = wd(SETS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [WAYS-1:0] set_valid,
   input  logic [IW-1:0]   idx,
   input  logic            commit,
   input  logic            clear,
   output logic [WW-1:0]   victim
);

   logic [WW-1:0] ptr [SETS];

   always_comb begin
      victim = ptr[idx];
      for (int w = WAYS - 1; w >= 0; w--)
         if (!set_valid[w]) victim = WW'(w);
   end

   // The pointer only advances when a full set forced a FIFO eviction.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         for (int s = 0; s < SETS; s++) ptr[s] <= '0;
      end else if (commit && &set_valid) begin
         ptr[idx] <= (ptr[idx] == WW'(WAYS - 1)) ? '0 : ptr[idx] + 1'b1;
      end
   end

endmodule

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative read-only instruction cache with FIFO replacement.
// Ports: clk/rst (sync, active-low); cpu_req/cpu_addr/flush in; cpu_ready/instr/hit/miss
//        out; mem_req/mem_addr refill beat request, mem_instr/mem_instr_valid refill data;
//        hit_count/miss_count saturating statistics.
module icache_nway
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WORD_SIZE   = 4,
   parameter int BLOCK_WORDS = 4,
   parameter int WAYS        = 2,
   parameter int CAPACITY    = 1024,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  flush,
   output logic                  cpu_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  hit,
   output logic                  miss,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_instr,
   input  logic                  mem_instr_valid,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic [CNT_WIDTH-1:0]  miss_count
);

   localparam int SETS = calc_sets(CAPACITY, WORD_SIZE, BLOCK_WORDS, WAYS);
   localparam int BOFF = lg(WORD_SIZE);
   localparam int WOFF = lg(BLOCK_WORDS);
   localparam int IDXB = lg(SETS);
   localparam int TAGW = ADDR_WIDTH - BOFF - WOFF - IDXB;
   localparam int WW   = wd(WAYS);
   localparam int BW   = wd(BLOCK_WORDS);
   localparam int IW   = wd(SETS);

   state_t                state;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [BW-1:0]         beat;
   logic                  flush_pend;
   logic [DATA_WIDTH-1:0] line_buf [BLOCK_WORDS];
   logic [WAYS-1:0]       valid    [SETS];
   logic [TAGW-1:0]       tag_mem  [SETS][WAYS];
   logic [DATA_WIDTH-1:0] data_mem [SETS][WAYS][BLOCK_WORDS];

   logic [IW-1:0]         idx;
   logic [BW-1:0]         word;
   logic [TAGW-1:0]       tag;
   logic [ADDR_WIDTH-1:0] line_base;
   logic                  last, fill_we, flush_now, hit_any;
   logic [DATA_WIDTH-1:0] hit_word;
   logic [WW-1:0]         victim;

   // Index/word fields collapse to constant 0 when their width is zero.
   assign idx       = (SETS == 1) ? '0 : IW'(req_addr >> (BOFF + WOFF));
   assign word      = (BLOCK_WORDS == 1) ? '0 : BW'(req_addr >> BOFF);
   assign tag       = TAGW'(req_addr >> (BOFF + WOFF + IDXB));
   assign line_base = (req_addr >> (BOFF + WOFF)) << (BOFF + WOFF);
   assign last      = beat == BW'(BLOCK_WORDS - 1);
   assign fill_we   = rst && state == REFILL && mem_instr_valid && last;
   assign flush_now = rst && state == IDLE && (flush || flush_pend);

   always_comb begin
      hit_any  = 1'b0;
      hit_word = '0;
      for (int w = 0; w < WAYS; w++)
         if (valid[idx][w] && tag_mem[idx][w] == tag) begin
            hit_any  = 1'b1;
            hit_word = data_mem[idx][w][word];
         end
   end

   icache_victim_sel #(.WAYS(WAYS), .SETS(SETS)) u_victim (
      .clk      (clk),
      .rst      (rst),
      .set_valid(valid[idx]),
      .idx      (idx),
      .commit   (fill_we),
      .clear    (flush_now),
      .victim   (victim)
   );

   // The final beat goes straight from mem_instr into the array alongside the buffered beats.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_mem[idx][victim] <= tag;
         for (int b = 0; b < BLOCK_WORDS; b++)
            data_mem[idx][victim][b] <= (b == BLOCK_WORDS - 1) ? mem_instr : line_buf[b];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         req_addr   <= '0;
         beat       <= '0;
         flush_pend <= 1'b0;
         cpu_ready  <= 1'b0;
         instr      <= '0;
         hit        <= 1'b0;
         miss       <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         for (int s = 0; s < SETS; s++) valid[s] <= '0;
      end else begin
         cpu_ready <= 1'b0;
         hit       <= 1'b0;
         miss      <= 1'b0;
         if (flush && state != IDLE) flush_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (flush || flush_pend) begin
                  for (int s = 0; s < SETS; s++) valid[s] <= '0;
                  flush_pend <= 1'b0;
               end else if (cpu_req) begin
                  req_addr <= cpu_addr;
                  state    <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit_any) begin
                  hit       <= 1'b1;
                  cpu_ready <= 1'b1;
                  instr     <= hit_word;
                  hit_count <= (&hit_count) ? hit_count : hit_count + 1'b1;
                  state     <= IDLE;
               end else begin
                  miss       <= 1'b1;
                  miss_count <= (&miss_count) ? miss_count : miss_count + 1'b1;
                  beat       <= '0;
                  mem_req    <= 1'b1;
                  mem_addr   <= line_base;
                  state      <= REFILL;
               end
            end
            REFILL: begin
               if (mem_instr_valid) begin
                  line_buf[beat] <= mem_instr;
                  beat           <= beat + 1'b1;
                  if (last) begin
                     valid[idx][victim] <= 1'b1;
                     mem_req            <= 1'b0;
                     state              <= RESPOND;
                  end else begin
                     mem_addr <= mem_addr + ADDR_WIDTH'(WORD_SIZE);
                  end
               end
            end
            RESPOND: begin
               cpu_ready <= 1'b1;
               instr     <= line_buf[word];
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed checks of icache_nway with a bench-side memory model.
module tb_icache_nway;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        flush = 1'b0;
   logic        cpu_ready, hit, miss, mem_req;
   logic [31:0] instr, mem_addr;
   logic [31:0] mem_instr = '0;
   logic        mem_instr_valid = 1'b0;
   logic [31:0] hit_count, miss_count;
   logic        s_cpu_ready, s_hit, s_miss, s_mem_req;
   logic [31:0] s_instr, s_mem_addr;
   logic [3:0]  s_hit_count, s_miss_count;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   icache_nway dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
      .cpu_ready(cpu_ready), .instr(instr), .hit(hit), .miss(miss),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_instr(mem_instr),
      .mem_instr_valid(mem_instr_valid), .hit_count(hit_count), .miss_count(miss_count)
   );

   icache_nway #(.CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
      .cpu_ready(s_cpu_ready), .instr(s_instr), .hit(s_hit), .miss(s_miss),
      .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_instr(mem_instr),
      .mem_instr_valid(mem_instr_valid), .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One fetch: request, lookup result, optional refill (with gaps / flush / reset
   // injected at a given beat), and the response.
   task automatic fetch(input logic [31:0] a, input bit exp_hit, input int gap,
                        input int fl_at, input int rst_at);
      logic [31:0] base;
      base = a & ~32'hF;
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = a;
      @(negedge clk);
      cpu_req = 1'b0;
      @(negedge clk);
      chk("hit", hit, exp_hit);
      chk("miss", miss, !exp_hit);
      if (exp_hit) begin
         chk("hit_ready", cpu_ready, 1);
         chk("hit_instr", instr, mem_word(a));
         chk("hit_memreq", mem_req, 0);
         return;
      end
      chk("miss_ready", cpu_ready, 0);
      for (int b = 0; b < 4; b++) begin
         chk("beat_memreq", mem_req, 1);
         chk("beat_addr", mem_addr, base + 32'(b * 4));
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("gap_memreq", mem_req, 1);
            chk("gap_addr", mem_addr, base + 32'(b * 4));
         end
         mem_instr       = mem_word(base + 32'(b * 4));
         mem_instr_valid = 1'b1;
         flush           = (b == fl_at);
         rst             = (b != rst_at);
         @(negedge clk);
         mem_instr_valid = 1'b0;
         flush           = 1'b0;
         if (b == rst_at) begin
            chk("rst_memreq", mem_req, 0);
            chk("rst_ready", cpu_ready, 0);
            chk("rst_misscnt", miss_count, 0);
            rst = 1'b1;
            return;
         end
      end
      chk("respond_memreq", mem_req, 0);
      chk("respond_early", cpu_ready, 0);
      @(negedge clk);
      chk("miss_ready_pulse", cpu_ready, 1);
      chk("miss_instr", instr, mem_word(a));
      chk("miss_hitflag", hit, 0);
      @(negedge clk);
      chk("ready_drop", cpu_ready, 0);
      chk("instr_hold", instr, mem_word(a));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", cpu_ready, 0);
      chk("rst_hit", hit, 0);
      chk("rst_miss", miss, 0);
      chk("rst_memreq", mem_req, 0);
      chk("rst_instr", instr, 0);
      chk("rst_memaddr", mem_addr, 0);
      chk("rst_hitcnt", hit_count, 0);
      chk("rst_misscnt", miss_count, 0);
      rst = 1'b1;

      fetch(32'h010, 0, 0, -1, -1);
      chk("cold_misscnt", miss_count, 1);
      fetch(32'h01C, 1, 0, -1, -1);
      chk("warm_hitcnt", hit_count, 1);

      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      fetch(32'h010, 0, 0, -1, -1);
      fetch(32'h210, 0, 0, -1, -1);
      fetch(32'h410, 0, 0, -1, -1);
      fetch(32'h210, 1, 0, -1, -1);
      fetch(32'h010, 0, 0, -1, -1);
      fetch(32'h210, 0, 0, -1, -1);
      chk("fifo_hitcnt", hit_count, 2);
      chk("fifo_misscnt", miss_count, 6);

      @(negedge clk);
      flush    = 1'b1;
      cpu_req  = 1'b1;
      cpu_addr = 32'h210;
      @(negedge clk);
      flush   = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("flushreq_hit", hit, 0);
      chk("flushreq_ready", cpu_ready, 0);
      chk("flushreq_miss", miss, 0);
      fetch(32'h010, 0, 0, -1, -1);

      fetch(32'h410, 0, 0, 1, -1);
      fetch(32'h010, 0, 0, -1, -1);
      chk("flush_misscnt", miss_count, 9);

      fetch(32'h610, 0, 3, -1, -1);
      chk("gap_misscnt", miss_count, 10);
      chk("gap_hitcnt", hit_count, 2);

      fetch(32'h030, 0, 3, -1, 2);
      fetch(32'h030, 0, 0, -1, -1);
      for (int i = 0; i < 20; i++) fetch(32'h034, 1, 0, -1, -1);
      chk("final_hitcnt", hit_count, 20);
      chk("final_misscnt", miss_count, 1);
      chk("sat_hitcnt", s_hit_count, 15);
      chk("sat_misscnt", s_miss_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
